obi_ram_responder: RTL and testbench
====================================

Name: obi_ram_responder

Overview:
- Single-port word-organised RAM exposed as an OBI responder on the core data bus.
- Accepts the core's req/gnt/rvalid transactions: byte-enabled writes and full-word reads.
- Programmable wait states before grant, so slow-memory timing can be exercised on the core side.
- Sits behind the bus address decoder as the data-RAM target.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0001_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 0: cycles req must be held before gnt; range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  transaction request from the initiator.
- we  input  1  1 = write, 0 = read; qualified by req.
- be  input  4  byte enables; be[i] selects wdata[8i+7:8i]. Writes only.
- addr  input  32  byte address; addr[1:0] ignored.
- wdata  input  32  write data.
- gnt  output  1  request accepted this cycle.
- rvalid  output  1  response phase; one pulse per granted transaction.
- rdata  output  32  read data; valid only while rvalid.

Behaviour:
- Reset (rst=1 at a clock edge): rvalid=0, rdata=0, wait counter=0, FSM=IDLE.
  - RAM contents are not cleared.
  - gnt=0 whenever rst=1.
  - A transaction granted in the cycle rst is asserted produces no rvalid and performs no write.
- Grant, WAIT_STATES=0:
  - gnt = req & ~rst, combinational.
  - Every cycle with req high is an accepted transaction.
  - Back-to-back: one transaction per cycle.
- Grant, WAIT_STATES=N>0: FSM with states IDLE and WAIT.
  - IDLE, req=1 → WAIT, counter loaded with N-1, gnt=0.
  - WAIT, counter≠0, req=1 → decrement, gnt=0.
  - WAIT, counter=0, req=1 → gnt=1 combinationally this cycle; return to IDLE.
  - Any state, req=0 → IDLE, counter cleared. This is a protocol violation, but the block must recover cleanly.
  - Net effect: gnt in the (N+1)th consecutive cycle of req. The next transaction waits again; minimum spacing is N+1 cycles.
  - Counter width is 4 bits.
- Response timing:
  - rvalid=1 exactly one cycle after each gnt, for reads and writes.
  - rvalid pulses for one cycle per transaction.
  - A new gnt may coincide with the rvalid of the previous transaction.
- Write: on the gnt edge, each byte with be[i]=1 is updated in the addressed word. be=0 → no change, still one rvalid.
- Read:
  - rdata is registered from the addressed word on the gnt edge and presented with rvalid.
  - rdata=0 in any cycle rvalid=0.
  - be ignored; the full word is returned.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH_WORDS.
  - Out-of-range requests are still granted and still get rvalid: writes are dropped, reads return 32'h0000_0000.
  - Wrap-around at the top of the 32-bit space counts as out of range, never as an alias.
- Ordering:
  - A read granted in the cycle after a write to the same word returns the new data.
  - No same-cycle read/write conflict is possible (one transaction per cycle).
- Inputs are sampled only in the grant cycle; addr/we/be/wdata may change freely afterwards.

Test Plan:
- Reset behaviour: WAIT_STATES=0. Write 32'hCAFE_F00D to BASE_ADDR; assert rst for 1 cycle during the rvalid cycle; then read BASE_ADDR → rvalid=0 in the reset cycle, read returns 32'hCAFE_F00D, rdata=0 outside rvalid.
- Byte enables: write 32'h1122_3344 be=4'hF to BASE_ADDR+8; write 32'hAABB_CCDD be=4'b0101; read → rdata=32'h11BB_33DD one cycle after gnt.
- Back-to-back pipelining: WAIT_STATES=0, req held 8 cycles (4 writes then 4 reads of words 0..3) → gnt every cycle, rvalid every cycle from cycle 2, reads return written values in order, no bubbles.
- Wait states: WAIT_STATES=3, hold req → gnt exactly in the 4th req cycle, rvalid in the 5th. Drop req after 2 cycles, then re-request → gnt again only after 4 more cycles.
- Out of range: read BASE_ADDR-4 and BASE_ADDR+4*DEPTH_WORDS → both granted, both rvalid with rdata=0. A write to BASE_ADDR+4*DEPTH_WORDS leaves word 0 unchanged.
- Index mapping: addr[1:0]=2'b11 on a read of BASE_ADDR+4 returns word 1. Writes to first and last word are read back correctly.

Source files
------------

// File: rtl/obi_ram_responder.sv
// OBI data-RAM responder: byte-enabled writes and full-word reads, with an optional
// fixed number of wait states before grant and a registered one-cycle response.
module obi_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = {1'b0, 32'(DEPTH_WORDS)} << 2;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [32:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_en;

  // 33-bit subtraction: an address below BASE_ADDR borrows into bit 32 and so
  // never compares below SPAN, which keeps wrap-around from aliasing into the RAM.
  assign offset   = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];

  assign gnt   = req & ~rst & ((WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd0));
  assign wr_en = gnt & we & in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!req) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_WAIT;
      cnt_d   = 4'(WAIT_STATES - 1);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    rvalid_d = gnt;
    rdata_d  = '0;
    if (gnt && !we && in_range) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_obi_ram_responder.sv
// Bench for obi_ram_responder: one instance without wait states, one with three,
// each checked against a transaction-level memory model.
module tb_obi_ram_responder;

  localparam int unsigned D    = 64;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned WS   = 3;

  logic clk = 1'b0;
  logic rst;
  logic req0, we0, gnt0, rvalid0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  logic req3, we3, gnt3, rvalid3;
  logic [3:0]  be3;
  logic [31:0] addr3, wdata3, rdata3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  obi_ram_responder #(.DEPTH_WORDS(D), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0), .addr(addr0),
    .wdata(wdata0), .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0)
  );

  obi_ram_responder #(.DEPTH_WORDS(D), .BASE_ADDR(BASE), .WAIT_STATES(WS)) u_ws3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .be(be3), .addr(addr3),
    .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3)
  );

  // Reference models: plain word arrays, plus a "known" flag for the wait-state RAM.
  logic [31:0] m0 [D];
  logic [31:0] m3 [D];
  bit          k3 [D];
  int          run3 = 0;
  logic [31:0] rd0_last;

  typedef struct {
    bit          w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 4 * D);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 4 * $urandom_range(1, 2);
      1:       return BASE + 4 * D + 4 * $urandom_range(0, 1);
      2:       return $urandom();
      default: return BASE + 4 * $urandom_range(0, D - 1) + $urandom_range(0, 3);
    endcase
  endfunction

  // One cycle on the zero-wait-state port; entered and left at a falling edge.
  task automatic cyc0(input bit rq, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input bit rs);
    bit          nrv;
    logic [31:0] nrd;
    req0 = rq; we0 = w; be0 = b; addr0 = a; wdata0 = d; rst = rs;
    #1;
    check("gnt0", gnt0, rq && !rs);
    nrv = rq && !rs;
    nrd = '0;
    if (nrv && in_rng(a)) begin
      if (w) m0[widx(a)] = merge(m0[widx(a)], d, b);
      else   nrd = m0[widx(a)];
    end
    @(posedge clk);
    @(negedge clk);
    check("rvalid0", rvalid0, nrv);
    check("rdata0", rdata0, nrd);
    rd0_last = rdata0;
    req0 = 1'b0; rst = 1'b0;
  endtask

  // One cycle on the three-wait-state port; grant expected once req has been
  // held for WS+1 consecutive cycles since the last grant or drop.
  task automatic cyc3(input bit rq, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output bit g_obs, output bit rv_obs,
                      output logic [31:0] rd_obs);
    bit          eg, known;
    logic [31:0] nrd;
    req3 = rq; we3 = w; be3 = b; addr3 = a; wdata3 = d;
    #1;
    eg = 1'b0;
    if (rq) begin
      run3++;
      if (run3 == WS + 1) begin
        eg   = 1'b1;
        run3 = 0;
      end
    end else begin
      run3 = 0;
    end
    g_obs = gnt3;
    check("gnt3", gnt3, eg);
    nrd   = '0;
    known = 1'b1;
    if (eg && in_rng(a)) begin
      if (w) begin
        m3[widx(a)] = merge(m3[widx(a)], d, b);
        k3[widx(a)] = k3[widx(a)] && (b == 4'hF) ? 1'b1 : (b == 4'hF);
      end else begin
        nrd   = m3[widx(a)];
        known = k3[widx(a)];
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("rvalid3", rvalid3, eg);
    if (known) check("rdata3", rdata3, nrd);
    rv_obs = rvalid3;
    rd_obs = rdata3;
    req3 = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    bit          g, rv;
    logic [31:0] rd;
    bit          gexp[8];
    bit          rvexp[8];

    vecs.push_back('{1'b1, 4'hF, BASE + 8,           32'h1122_3344, 32'h0});
    vecs.push_back('{1'b1, 4'h5, BASE + 8,           32'hAABB_CCDD, 32'h0});
    vecs.push_back('{1'b0, 4'h0, BASE + 8,           32'h0,         32'h11BB_33DD});
    vecs.push_back('{1'b0, 4'hF, BASE - 4,           32'h0,         32'h0});
    vecs.push_back('{1'b0, 4'hF, BASE + 4 * D,       32'h0,         32'h0});
    vecs.push_back('{1'b1, 4'hF, BASE + 4 * D,       32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, BASE,               32'h0,         32'hCAFE_F00D});
    vecs.push_back('{1'b1, 4'hF, BASE + 4,           32'h1234_5678, 32'h0});
    vecs.push_back('{1'b0, 4'h0, BASE + 7,           32'h0,         32'h1234_5678});
    vecs.push_back('{1'b1, 4'h0, BASE + 4,           32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 4'hF, BASE + 4,           32'h0,         32'h1234_5678});
    vecs.push_back('{1'b1, 4'hF, BASE,               32'h0F0F_0F0F, 32'h0});
    vecs.push_back('{1'b1, 4'hF, BASE + 4 * (D - 1), 32'hF0F0_F0F0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, BASE,               32'h0,         32'h0F0F_0F0F});
    vecs.push_back('{1'b0, 4'h0, BASE + 4 * (D - 1), 32'h0,         32'hF0F0_F0F0});
    vecs.push_back('{1'b1, 4'hF, 32'hFFFF_FFFC,      32'hBAD0_BAD0, 32'h0});
    vecs.push_back('{1'b0, 4'hF, 32'hFFFF_FFFC,      32'h0,         32'h0});
    vecs.push_back('{1'b0, 4'hF, BASE + 4 * (D - 1), 32'h0,         32'hF0F0_F0F0});

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; be0 = '0; addr0 = '0; wdata0 = '0;
    req3 = 1'b0; we3 = 1'b0; be3 = '0; addr3 = '0; wdata3 = '0;
    for (int i = 0; i < D; i++) k3[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rvalid0", rvalid0, 1'b0);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_rvalid3", rvalid3, 1'b0);
    check("reset_rdata3", rdata3, 32'h0);
    req0 = 1'b1;
    #1;
    check("reset_gnt0", gnt0, 1'b0);
    req0 = 1'b0;
    rst  = 1'b0;

    for (int i = 0; i < D; i++) cyc0(1, 1, 4'hF, BASE + 4 * i, 32'hA5A5_0000 ^ (i * 32'h0101_0101), 0);

    // Reset asserted during the write's response cycle, with a read also requested.
    cyc0(1, 1, 4'hF, BASE, 32'hCAFE_F00D, 0);
    cyc0(1, 0, 4'hF, BASE, 32'h0, 1);
    check("rst_rvalid_dropped", rvalid0, 1'b0);
    cyc0(0, 0, 4'h0, BASE, 32'h0, 0);
    cyc0(1, 0, 4'h0, BASE, 32'h0, 0);
    check("rst_readback", rd0_last, 32'hCAFE_F00D);

    foreach (vecs[i]) begin
      cyc0(1, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, 0);
      check($sformatf("vec%0d_rdata", i), rd0_last, vecs[i].exp);
    end

    for (int i = 0; i < 4; i++) cyc0(1, 1, 4'hF, BASE + 4 * i, 32'h1111_1111 * (i + 1), 0);
    for (int i = 0; i < 4; i++) begin
      cyc0(1, 0, 4'h0, BASE + 4 * i, 32'h0, 0);
      check($sformatf("pipe_rd%0d", i), rd0_last, 32'h1111_1111 * (i + 1));
    end

    for (int n = 0; n < 300; n++) begin
      cyc0($urandom_range(0, 3) != 0, $urandom_range(0, 1), 4'($urandom()), rand_addr(),
           $urandom(), $urandom_range(0, 49) == 0);
    end

    gexp  = '{0, 0, 0, 1, 0, 0, 0, 1};
    rvexp = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      cyc3(1, 1, 4'hF, BASE + 12, 32'h5555_AAAA, g, rv, rd);
      check($sformatf("ws_wr_gnt%0d", i), g, gexp[i]);
      check($sformatf("ws_wr_rvalid%0d", i), rv, rvexp[i]);
    end
    cyc3(0, 0, 4'h0, BASE, 32'h0, g, rv, rd);
    for (int i = 0; i < 2; i++) begin
      cyc3(1, 0, 4'h0, BASE + 12, 32'h0, g, rv, rd);
      check($sformatf("ws_drop_gnt%0d", i), g, 1'b0);
    end
    cyc3(0, 0, 4'h0, BASE, 32'h0, g, rv, rd);
    for (int i = 0; i < 4; i++) begin
      cyc3(1, 0, 4'h0, BASE + 12, 32'h0, g, rv, rd);
      check($sformatf("ws_rereq_gnt%0d", i), g, gexp[i]);
    end
    check("ws_rd_rdata", rd, 32'h5555_AAAA);
    for (int i = 0; i < 8; i++) begin
      cyc3(1, 0, 4'h0, BASE + 12, 32'h0, g, rv, rd);
      check($sformatf("ws_hold_gnt%0d", i), g, gexp[i]);
    end
    cyc3(0, 0, 4'h0, BASE, 32'h0, g, rv, rd);

    for (int n = 0; n < 250; n++) begin
      cyc3($urandom_range(0, 7) != 0, $urandom_range(0, 1), 4'($urandom()), rand_addr(),
           $urandom(), g, rv, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
